if_fetch_unit: RTL and testbench

- Instruction-fetch stage of the 5-stage RISC-V pipeline: the producer that writes the IF/ID pipeline register.
- Owns the PC and issues word fetches to instruction memory over a req/ready handshake.
- Presents instr_out/pc_out/valid_out to IF/ID, inserting canonical NOPs (32'h00000013) on bubbles.
- Honours stall from hazard logic and redirect from branch/jump resolution.

---
 rtl/if_pkg.sv | 22 ++
 rtl/if_fetch_unit_pc_gen.sv | 44 ++++
 rtl/if_fetch_unit.sv | 173 +++++++++++++++++
 tb/tb_if_fetch_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_KILL  = 2'd3
  } fetch_state_e;

  // An all-zero word is never a legal instruction; it is treated as a bubble.
  function automatic logic [XLEN-1:0] canon_instr(input logic [XLEN-1:0] word,
                                                 input logic [XLEN-1:0] nop);
    return (word == '0) ? nop : word;
  endfunction

endpackage

// File: rtl/if_fetch_unit_pc_gen.sv
// Program counter: reset value, sequential +4 advance and redirect load.
// With FETCH_MISALIGN_CHECK_EN defined, redirect targets are forced word-aligned.
module pc_gen
  import if_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            advance,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] target;

  always_comb begin
`ifdef FETCH_MISALIGN_CHECK_EN
    target = redirect_pc & ~32'h0000_0003;
`else
    target = redirect_pc;
`endif
    pc_d = pc_q;
    if (load_redirect) begin
      pc_d = target;
    end else if (advance) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: issues word fetches, feeds IF/ID, handles stall and redirect.
// Optional FETCH_MISALIGN_CHECK_EN adds the fetch_misaligned flag and aligned redirects.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = if_pkg::NOP_INSTR
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      redirect,
  input  logic [if_pkg::XLEN-1:0]   redirect_pc,
  output logic                      imem_req,
  output logic [if_pkg::XLEN-1:0]   imem_addr,
  input  logic                      imem_ready,
  input  logic [if_pkg::XLEN-1:0]   imem_rdata,
  output logic [if_pkg::XLEN-1:0]   instr_out,
  output logic [if_pkg::XLEN-1:0]   pc_out,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic                      fetch_misaligned,
`endif
  output logic                      valid_out
);
  import if_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] hold_instr_q, hold_instr_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;
  logic [XLEN-1:0] kill_addr_q, kill_addr_d;
  logic            launched_q, launched_d;
  logic [XLEN-1:0] pc;
  logic            req;
  logic            rsp;
  logic            pc_advance;
  logic [XLEN-1:0] fetched_instr;

  pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk           (clk),
    .reset         (reset),
    .load_redirect (redirect),
    .redirect_pc   (redirect_pc),
    .advance       (pc_advance),
    .pc            (pc)
  );

  // A request only starts while IF/ID is accepting, but once seen by memory it must stay up.
  always_comb begin
    req = 1'b0;
    case (state_q)
      ST_FETCH: req = launched_q || !stall;
      ST_KILL:  req = 1'b1;
      default:  req = 1'b0;
    endcase
  end

  assign rsp           = req && imem_ready;
  assign fetched_instr = canon_instr(imem_rdata, NOP_INSTR);

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    valid_d      = valid_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    kill_addr_d  = kill_addr_q;
    launched_d   = launched_q;
    pc_advance   = 1'b0;

    if (redirect) begin
      instr_d    = NOP_INSTR;
      valid_d    = 1'b0;
      launched_d = 1'b0;
      if (state_q == ST_KILL) begin
        state_d = imem_ready ? ST_FETCH : ST_KILL;
      end else if (req && !imem_ready) begin
        // Memory already saw this address; keep it stable until the stale word returns.
        state_d     = ST_KILL;
        kill_addr_d = pc;
      end else begin
        state_d = ST_FETCH;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_FETCH;
        end
        ST_FETCH: begin
          if (rsp) begin
            pc_advance = 1'b1;
            launched_d = 1'b0;
            if (stall) begin
              hold_instr_d = fetched_instr;
              hold_pc_d    = pc;
              state_d      = ST_HOLD;
            end else begin
              instr_d  = fetched_instr;
              pc_out_d = pc;
              valid_d  = 1'b1;
            end
          end else begin
            launched_d = req;
            if (!stall) begin
              instr_d = NOP_INSTR;
              valid_d = 1'b0;
            end
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            instr_d  = hold_instr_q;
            pc_out_d = hold_pc_q;
            valid_d  = 1'b1;
            state_d  = ST_FETCH;
          end
        end
        ST_KILL: begin
          if (imem_ready) begin
            state_d = ST_FETCH;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misaligned_q, misaligned_d;
  assign misaligned_d     = redirect && (redirect_pc[1:0] != 2'b00);
  assign fetch_misaligned = misaligned_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      instr_q      <= NOP_INSTR;
      pc_out_q     <= '0;
      valid_q      <= 1'b0;
      hold_instr_q <= NOP_INSTR;
      hold_pc_q    <= '0;
      kill_addr_q  <= RESET_PC;
      launched_q   <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
      valid_q      <= valid_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      kill_addr_q  <= kill_addr_d;
      launched_q   <= launched_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      misaligned_q <= misaligned_d;
`endif
    end
  end

  assign imem_req  = req;
  assign imem_addr = (state_q == ST_KILL) ? kill_addr_q : pc;
  assign instr_out = instr_q;
  assign pc_out    = pc_out_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized and directed bench for if_fetch_unit against a transaction-level reference model.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        fetch_misaligned;

  logic        rst2 = 1'b1;
  logic        req2;
  logic [31:0] addr2;
  logic [31:0] instr2;
  logic [31:0] pc2;
  logic        valid2;
  logic        mis2;

  int n_checks = 0;
  int n_errors = 0;

  // memory image: either one constant word or an address hash with some zero words
  logic        const_mode = 1'b1;
  logic [31:0] const_word = 32'h0050_0093;

  // reference model: what the fetch stage owes IF/ID, in transaction terms
  logic        m_first, m_inflight, m_discard, m_held, m_valid, m_mis;
  logic [31:0] m_pc, m_req_addr, m_held_instr, m_held_pc, m_instr, m_pcout;

  if_fetch_unit u_dut (
`ifdef FETCH_MISALIGN_CHECK_EN
    .fetch_misaligned (fetch_misaligned),
`endif
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr_out   (instr_out),
    .pc_out      (pc_out),
    .valid_out   (valid_out)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
`ifdef FETCH_MISALIGN_CHECK_EN
    .fetch_misaligned (mis2),
`endif
    .clk         (clk),
    .reset       (rst2),
    .stall       (1'b0),
    .redirect    (1'b0),
    .redirect_pc (32'h0),
    .imem_req    (req2),
    .imem_addr   (addr2),
    .imem_ready  (1'b1),
    .imem_rdata  (32'h0050_0093),
    .instr_out   (instr2),
    .pc_out      (pc2),
    .valid_out   (valid2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    if (const_mode) return const_word;
    w = (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    if (w[3:0] == 4'h0) return 32'h0;
    return w;
  endfunction

  function automatic logic [31:0] target_of(input logic [31:0] rpc);
`ifdef FETCH_MISALIGN_CHECK_EN
    return {rpc[31:2], 2'b00};
`else
    return rpc;
`endif
  endfunction

  task automatic model_reset();
    m_first = 1'b1; m_inflight = 1'b0; m_discard = 1'b0; m_held = 1'b0;
    m_pc = 32'h0; m_req_addr = 32'h0; m_held_instr = NOP; m_held_pc = 32'h0;
    m_instr = NOP; m_pcout = 32'h0; m_valid = 1'b0; m_mis = 1'b0;
  endtask

  // Called at a falling edge: drive one cycle of inputs, check, advance to next falling edge.
  task automatic step(input logic s, input logic r, input logic [31:0] rpc, input logic rdy);
    logic        exp_req;
    logic [31:0] exp_addr, word;
    stall = s; redirect = r; redirect_pc = rpc; imem_ready = rdy;
    imem_rdata = mem_word(imem_addr);
    exp_req  = (m_first || m_held) ? 1'b0 : (m_discard ? 1'b1 : (m_inflight || !s));
    exp_addr = m_discard ? m_req_addr : m_pc;
    #1;
    chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    chk("imem_addr", imem_addr, exp_addr);

    m_mis = r && (rpc[1:0] != 2'b00);
    if (r) begin
      m_discard  = exp_req && !rdy;
      m_req_addr = exp_addr;
      m_pc = target_of(rpc); m_instr = NOP; m_valid = 1'b0;
      m_held = 1'b0; m_inflight = 1'b0; m_first = 1'b0;
    end else if (m_first) begin
      m_first = 1'b0;
    end else if (m_discard) begin
      if (rdy) m_discard = 1'b0;
    end else if (m_held) begin
      if (!s) begin
        m_instr = m_held_instr; m_pcout = m_held_pc; m_valid = 1'b1; m_held = 1'b0;
      end
    end else if (exp_req && rdy) begin
      word = mem_word(m_pc);
      if (word == 32'h0) word = NOP;
      if (s) begin
        m_held = 1'b1; m_held_instr = word; m_held_pc = m_pc;
      end else begin
        m_instr = word; m_pcout = m_pc; m_valid = 1'b1;
      end
      m_pc = m_pc + 32'd4;
      m_inflight = 1'b0;
    end else begin
      m_inflight = exp_req;
      if (!s) begin
        m_instr = NOP; m_valid = 1'b0;
      end
    end

    @(posedge clk);
    @(negedge clk);
    chk("instr_out", instr_out, m_instr);
    chk("pc_out", pc_out, m_pcout);
    chk("valid_out", {31'b0, valid_out}, {31'b0, m_valid});
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("fetch_misaligned", {31'b0, fetch_misaligned}, {31'b0, m_mis});
`endif
  endtask

  // Reset asserted between edges must take effect at once.
  task automatic do_reset();
    #2;
    reset = 1'b1; imem_ready = 1'b1; stall = 1'b0; redirect = 1'b0;
    #1;
    chk("rst_instr", instr_out, NOP);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_valid", {31'b0, valid_out}, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // zero-wait streaming, constant word
    const_mode = 1'b1; const_word = 32'h0050_0093;
    step(0, 0, 0, 1);
    chk("stream_valid_first_edge", {31'b0, valid_out}, 32'h0);
    step(0, 0, 0, 1);
    chk("stream_pc0", pc_out, 32'h0);
    chk("stream_valid", {31'b0, valid_out}, 32'h1);
    chk("stream_instr", instr_out, 32'h0050_0093);
    step(0, 0, 0, 1);
    chk("stream_pc4", pc_out, 32'h4);
    step(0, 0, 0, 1);
    chk("stream_pc8", pc_out, 32'h8);
    const_word = 32'h0;
    step(0, 0, 0, 1);
    chk("zero_word_nop", instr_out, NOP);
    chk("zero_word_valid", {31'b0, valid_out}, 32'h1);

    // response arrives while stalled, held, then released
    do_reset();
    const_word = 32'h0050_0093;
    step(0, 0, 0, 1); step(0, 0, 0, 1); step(0, 0, 0, 1);
    const_word = 32'h00A0_0113;
    step(0, 0, 0, 0);
    step(1, 0, 0, 1);
    chk("stall_frozen_pc", pc_out, 32'h4);
    step(1, 0, 0, 0);
    chk("stall_frozen_valid", {31'b0, valid_out}, 32'h0);
    step(0, 0, 0, 0);
    chk("hold_instr", instr_out, 32'h00A0_0113);
    chk("hold_pc", pc_out, 32'h8);
    chk("hold_valid", {31'b0, valid_out}, 32'h1);
    chk("hold_next_addr", imem_addr, 32'hC);

    // redirect while a request is outstanding, ready three cycles late
    const_mode = 1'b0;
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 1, 32'h100, 0);
    chk("kill_keeps_addr", imem_addr, 32'h10);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("kill_no_valid", {31'b0, valid_out}, 32'h0);
    chk("kill_instr_nop", instr_out, NOP);
    chk("kill_next_addr", imem_addr, 32'h100);
    step(0, 0, 0, 1);
    chk("redir_pc_out", pc_out, 32'h100);
    chk("redir_valid", {31'b0, valid_out}, 32'h1);

`ifdef FETCH_MISALIGN_CHECK_EN
    step(1, 1, 32'h102, 0);
    chk("mis_pulse", {31'b0, fetch_misaligned}, 32'h1);
    chk("mis_aligned_addr", imem_addr, 32'h100);
    step(0, 0, 0, 0);
    chk("mis_clear", {31'b0, fetch_misaligned}, 32'h0);
`endif

    // randomized traffic with occasional mid-flight resets
    for (int i = 0; i < 4000; i++) begin
      if (i % 997 == 500) do_reset();
      step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
           $urandom(), $urandom_range(0, 2) != 0);
    end

    // pc wraps from the top of the address space
    rst2 = 1'b0;
    @(negedge clk);
    chk("wrap_idle_valid", {31'b0, valid2}, 32'h0);
    @(negedge clk);
    chk("wrap_pc_top", pc2, 32'hFFFF_FFFC);
    chk("wrap_valid", {31'b0, valid2}, 32'h1);
    @(negedge clk);
    chk("wrap_pc_zero", pc2, 32'h0);
    chk("wrap_addr", addr2, 32'h4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
